// File: rtl/xor_descrambler.sv
// Self-synchronizing x^7+x^6+1 serial descrambler with frame parity checking.
// Hunts for 7 bits to fill the history register, then streams descrambled bits.
module xor_descrambler #(
    parameter int FRAME_LEN = 8,
    parameter int ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    output logic             out_bit,
    input  logic             out_ready,
    output logic             locked,
    output logic             frame_err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int              FW      = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [FW-1:0]   LAST    = FW'(FRAME_LEN - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [6:0]    s;
    logic [2:0]    fill;
    logic [FW-1:0] fpos;
    logic          fpar;
    logic          accept;
    logic          dbit;
    logic          err_hit;

    // A bit moves on a side when valid and ready are both high at the rising edge;
    // the input side is ready whenever the single output slot is empty or draining.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign dbit     = in_bit ^ s[6] ^ s[5];
    assign locked   = (state == RUN);
    assign err_hit  = accept && (state == RUN) && (fpos == LAST) && (fpar ^ dbit);

    always_comb begin
        state_nxt = state;
        if (state == HUNT && accept && fill == 3'd6) begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s         <= '0;
            fill      <= '0;
            fpos      <= '0;
            fpar      <= 1'b0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            frame_err <= err_hit;
            if (err_hit && err_cnt != ERR_MAX) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (accept) begin
                s <= {s[5:0], in_bit};
            end
            if (accept && state == HUNT) begin
                fill <= fill + 3'd1;
            end
            // The running parity restarts after each parity bit so frames stay independent.
            if (accept && state == RUN) begin
                out_bit   <= dbit;
                out_valid <= 1'b1;
                if (fpos == LAST) begin
                    fpos <= '0;
                    fpar <= 1'b0;
                end else begin
                    fpos <= fpos + 1'b1;
                    fpar <= fpar ^ dbit;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_xor_descrambler.sv
// Directed bench for xor_descrambler: scrambles known plaintext, injects channel
// flips, and scoreboards every emitted bit and parity-error pulse.
module tb_xor_descrambler;

    localparam int FRAME_LEN = 8;
    localparam int ERR_W     = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_bit = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic             out_bit;
    logic             out_ready = 1'b1;
    logic             locked;
    logic             frame_err;
    logic [ERR_W-1:0] err_cnt;

    int checks = 0;
    int failures = 0;

    // scoreboard entry: {expected frame_err, expected out_bit}
    logic [1:0] exp_q[$];
    logic [6:0] t;
    logic [6:0] fh;
    int         acc_n;
    int         fpos;
    logic       fpar;
    int         exp_err_total;
    int         pulse_cnt;
    logic       fresh = 1'b0;

    xor_descrambler #(.FRAME_LEN(FRAME_LEN), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_ready (out_ready),
        .locked    (locked),
        .frame_err (frame_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            fresh = 1'b0;
        end else begin
            if (frame_err) pulse_cnt++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", out_valid, 0);
                end else begin
                    if (fresh) chk("frame_err", frame_err, exp_q[0][1]);
                    else       chk("frame_err_held", frame_err, 0);
                    if (out_ready) begin
                        chk("out_bit", out_bit, exp_q[0][0]);
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                chk("frame_err_idle", frame_err, 0);
            end
            fresh = in_valid && in_ready;
        end
    end

    task automatic check_reset_outs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_bit"}, out_bit, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_frame_err"}, frame_err, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    // Asserts reset between edges, checks outputs immediately, then releases.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
        t = '0; fh = '0; acc_n = 0; fpos = 0; fpar = 1'b0;
        exp_err_total = 0; pulse_cnt = 0;
        #1;
        check_reset_outs(tag);
        repeat (2) @(negedge clk);
        check_reset_outs(tag);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Scrambles plaintext p, optionally flips it on the wire, and queues the expectation.
    task automatic send_bit(input logic p, input logic f);
        logic c, e, err;
        int n;
        c = p ^ t[6] ^ t[5];
        in_valid = 1'b1;
        in_bit = c ^ f;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", in_ready, 1);
        if (in_ready) begin
            e = p ^ f ^ fh[5] ^ fh[6];
            if (acc_n >= 7) begin
                if (fpos == FRAME_LEN - 1) begin
                    err = fpar ^ e;
                    fpos = 0;
                    fpar = 1'b0;
                    if (err) exp_err_total++;
                end else begin
                    err = 1'b0;
                    fpar = fpar ^ e;
                    fpos++;
                end
                exp_q.push_back({err, e});
            end
            t = {t[5:0], c};
            fh = {fh[5:0], f};
            acc_n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic sync_pads();
        for (int i = 0; i < 7; i++) begin
            send_bit(1'($urandom_range(0, 1)), 1'b0);
            chk("hunt_locked", locked, (i == 6) ? 1 : 0);
            chk("hunt_out_valid", out_valid, 0);
        end
    endtask

    task automatic send_frame(input logic [6:0] payload, input logic bad, input int flip_pos);
        logic par;
        par = (^payload) ^ bad;
        for (int i = 0; i < FRAME_LEN; i++) begin
            send_bit((i < 7) ? payload[i] : par, (i == flip_pos));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || out_valid) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [6:0] pl;
        logic       held;
        int         sat_exp[5];
        sat_exp = '{1, 2, 3, 3, 3};

        // Power-up reset, hunt, and a known clean frame.
        do_reset("por");
        sync_pads();
        send_frame(7'b1001101, 1'b0, -1);
        drain();
        chk("clean_err_cnt", err_cnt, 0);
        chk("clean_pulses", pulse_cnt, 0);

        for (int k = 0; k < 3; k++) begin
            send_frame(7'($urandom_range(0, 127)), 1'b0, -1);
        end
        drain();
        chk("random_err_cnt", err_cnt, 0);

        // Stall: slot full, downstream blocked for 10 cycles while input waits.
        pl = 7'($urandom_range(0, 127));
        out_ready = 1'b0;
        send_bit(pl[0], 1'b0);
        fork
            send_bit(pl[1], 1'b0);
            begin
                @(negedge clk);
                held = out_bit;
                repeat (10) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_out_bit", out_bit, held);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        for (int i = 2; i < FRAME_LEN; i++) begin
            send_bit((i < 7) ? pl[i] : ^pl, 1'b0);
        end
        drain();
        chk("stall_err_cnt", err_cnt, 0);

        // Reset mid-frame while stalled: buffered bit and frame position discarded.
        send_frame(7'($urandom_range(0, 127)), 1'b0, -1);
        drain();
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset("midframe");
        sync_pads();
        send_frame(7'($urandom_range(0, 127)), 1'b0, -1);
        send_frame(7'($urandom_range(0, 127)), 1'b0, -1);
        drain();
        chk("post_reset_err_cnt", err_cnt, 0);

        // Channel flips: each spreads to delays 6 and 7.
        do_reset("flip");
        sync_pads();
        send_frame(7'($urandom_range(0, 127)), 1'b0, 3);
        send_frame(7'($urandom_range(0, 127)), 1'b0, -1);
        send_frame(7'($urandom_range(0, 127)), 1'b0, 1);
        send_frame(7'($urandom_range(0, 127)), 1'b0, -1);
        drain();
        chk("flip_pulses", pulse_cnt, exp_err_total);
        chk("flip_err_cnt", err_cnt, exp_err_total);

        // Saturation of the 2-bit error counter over five bad frames.
        do_reset("sat");
        sync_pads();
        for (int k = 0; k < 5; k++) begin
            send_frame(7'($urandom_range(0, 127)), 1'b1, -1);
            drain();
            chk("sat_err_cnt", err_cnt, sat_exp[k]);
        end
        chk("sat_pulses", pulse_cnt, 5);
        chk("sat_locked", locked, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xor_descrambler.md
XOR_DESCRAMBLER -- requirements
Module: xor_descrambler

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 8, meaning descrambled bits per parity frame, legal range 2..64.
REQ-002 The block SHALL have parameter ERR_W, default 8, meaning width of the parity-error counter.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid  input  1  a scrambled bit is offered on in_bit.
REQ-006 The block SHALL have port in_bit  input  1  scrambled serial data.
REQ-007 The block SHALL have port in_ready  output  1  the block accepts in_bit this cycle.
REQ-008 The block SHALL have port out_valid  output  1  out_bit holds a descrambled bit.
REQ-009 The block SHALL have port out_bit  output  1  descrambled serial data.
REQ-010 The block SHALL have port out_ready  input  1  the downstream consumes out_bit this cycle.
REQ-011 The block SHALL have port locked  output  1  the block is in state RUN.
REQ-012 The block SHALL have port frame_err  output  1  one-cycle pulse on a frame parity failure.
REQ-013 The block SHALL have port err_cnt  output  ERR_W  saturating count of parity failures.

Function
REQ-014 Input accept SHALL be in_valid && in_ready; output transfer SHALL be out_valid && out_ready.
REQ-015 in_ready SHALL equal !out_valid || out_ready (one-entry output buffer, no combinational path from in_valid to out_valid).
REQ-016 The descrambler SHALL be self-synchronizing, polynomial x^7+x^6+1: on accept, d = in_bit ^ s[6] ^ s[5], then s <= {s[5:0], in_bit}.
REQ-017 The state machine SHALL have states HUNT and RUN; reset state HUNT.
REQ-018 In HUNT, accepts SHALL only shift s and increment fill count; out_valid SHALL stay 0.
REQ-019 HUNT -> RUN SHALL occur on the 7th accepted bit; that bit itself SHALL NOT be emitted; locked rises the cycle after.
REQ-020 In RUN, each accept SHALL load d into out_bit and set out_valid the next cycle (latency 1 cycle).
REQ-021 out_valid SHALL clear on an output transfer with no simultaneous accept; simultaneous transfer and accept SHALL keep out_valid at 1 with the new bit.
REQ-022 In RUN, a frame counter SHALL count emitted bits 0..FRAME_LEN-1 and wrap to 0; positions 0..FRAME_LEN-2 are payload and position FRAME_LEN-1 is an even-parity bit over the frame's payload.
REQ-023 On the parity bit, if the XOR of all FRAME_LEN bits is 1, frame_err SHALL pulse high for exactly one cycle, coincident with out_valid of that bit.
REQ-024 err_cnt SHALL increment by 1 on each frame_err and saturate at 2^ERR_W-1, never wrapping.
REQ-025 Parity bits SHALL still be emitted on out_bit; the block SHALL NOT drop or insert bits.
REQ-026 RUN SHALL persist for the stream; the only return to HUNT is reset.
REQ-027 Stalls (out_ready=0) SHALL hold out_bit, out_valid, s and frame counter unchanged.

Reset
REQ-028 While rst_n=0, all of these SHALL hold: s=0, fill count=0, frame counter=0, state=HUNT, out_valid=0, out_bit=0, locked=0, frame_err=0, err_cnt=0, in_ready=1.
REQ-029 Assertion of rst_n mid-frame or mid-stall SHALL discard the buffered bit and all partial frame state immediately, without waiting for a clock edge.
REQ-030 Deassertion of rst_n SHALL be synchronized externally; the first accept can occur on the first rising edge after release.

Verification
REQ-031 Bench: 7 accepted bits after reset -> out_valid=0 throughout, locked=1 the cycle after the 7th accept.
REQ-032 Bench: scrambled stream of payload 1,0,1,1,0,0,1 plus parity 0 (FRAME_LEN=8), out_ready=1 -> same 8 bits on out_bit, frame_err never high, err_cnt=0.
REQ-033 Bench: single in_bit flip in one frame -> descrambled errors at that bit and at delays 6 and 7 from it; frame_err pulses once per affected frame with odd error count; err_cnt matches the pulse count.
REQ-034 Bench: ERR_W=2, 5 bad frames -> err_cnt reads 1,2,3,3,3.
REQ-035 Bench: out_ready=0 for 10 cycles with in_valid=1 -> in_ready=0, out_bit stable; on release, next bit follows with no loss or duplication.
REQ-036 Bench: rst_n pulsed low mid-frame -> all outputs at reset values while low; locked=0 until 7 new accepts.
